// File: rtl/pwm_multi_led_if.sv
// Duty-write bus between the register/control logic and the PWM block.
// duty_wr is a one-cycle strobe with no ready: every write is taken in the cycle it is seen.
interface pwm_multi_led_if #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 2
) ();
  logic                 duty_wr;
  logic [SEL_WIDTH-1:0] duty_sel;
  logic [WIDTH-1:0]     duty_data;

  modport master (output duty_wr, output duty_sel, output duty_data);
  modport slave  (input  duty_wr, input  duty_sel, input  duty_data);
endinterface

// File: rtl/pwm_multi_led.sv
// Multi-channel PWM with shared prescaled period counter, edge/center alignment
// and double-buffered duty registers that load only at a period boundary.
module pwm_multi_led #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 8,
  parameter int SEL_WIDTH      = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      center_mode,
  pwm_multi_led_if.slave            duty_bus,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start
);

  localparam logic [WIDTH-1:0]          CNT_MAX = '1;
  localparam logic [WIDTH-1:0]          CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [WIDTH-1:0]          cnt;
  logic [WIDTH-1:0]          cnt_next;
  logic                      dir;
  logic                      dir_next;
  logic                      mode;
  logic                      tick;
  logic                      boundary;
  logic [WIDTH-1:0]          shadow      [CHANNELS];
  logic [WIDTH-1:0]          shadow_next [CHANNELS];
  logic [WIDTH-1:0]          active      [CHANNELS];

  // >= rather than == so a prescale shrunk below pre_cnt ticks at once
  always_comb begin
    tick = enable && (pre_cnt >= prescale);
  end

  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    if (!mode) begin
      cnt_next = cnt + CNT_ONE;
    end else if (!dir) begin
      if (cnt == CNT_MAX) begin
        cnt_next = CNT_MAX - CNT_ONE;
        dir_next = 1'b1;
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else begin
      cnt_next = cnt - CNT_ONE;
    end
    boundary = tick && (cnt_next == '0);
  end

  // Out-of-range selects match no channel and are dropped
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      shadow_next[i] = shadow[i];
      if (duty_bus.duty_wr && (int'(duty_bus.duty_sel) == i)) begin
        shadow_next[i] = duty_bus.duty_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt      <= '0;
      cnt          <= '0;
      dir          <= 1'b0;
      mode         <= 1'b0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= shadow_next[i];
      end
      period_start <= boundary;
      if (!enable) begin
        pre_cnt <= '0;
        cnt     <= '0;
        dir     <= 1'b0;
        pwm_out <= '0;
        for (int i = 0; i < CHANNELS; i++) begin
          active[i] <= shadow_next[i];
        end
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_ONE;
        if (tick) begin
          cnt <= cnt_next;
          dir <= boundary ? 1'b0 : dir_next;
        end
        // shadow_next gives the same-cycle write bypass into active
        if (boundary) begin
          mode <= center_mode;
          for (int i = 0; i < CHANNELS; i++) begin
            active[i] <= shadow_next[i];
          end
        end
        for (int i = 0; i < CHANNELS; i++) begin
          pwm_out[i] <= (cnt < active[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_led.sv
// Directed bench for pwm_multi_led: table of duty/prescale/mode vectors plus
// hand sequences for double buffering, bypass, center shape, reset and enable.
module tb_pwm_multi_led;

  localparam int CHANNELS = 2;
  localparam int WIDTH    = 4;
  localparam int PW       = 8;
  localparam int SW       = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic                enable;
  logic [PW-1:0]       prescale;
  logic                center_mode;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_start;

  pwm_multi_led_if #(.WIDTH(WIDTH), .SEL_WIDTH(SW)) duty_bus ();

  pwm_multi_led #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .PRESCALE_WIDTH(PW), .SEL_WIDTH(SW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .prescale(prescale),
    .center_mode(center_mode), .duty_bus(duty_bus),
    .pwm_out(pwm_out), .period_start(period_start)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int d0; int d1; int pre; int ctr; int n; int h0; int h1; int ps;
  } vec_t;
  vec_t vecs [6];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_duty(input int sel, input int data);
    duty_bus.duty_wr   = 1'b1;
    duty_bus.duty_sel  = sel[SW-1:0];
    duty_bus.duty_data = data[WIDTH-1:0];
    step();
    duty_bus.duty_wr   = 1'b0;
  endtask

  task automatic wait_ps(input string name, output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (period_start) begin
        lat = k;
        break;
      end
    end
    check(name, (lat > 0) ? 1 : 0, 1);
  endtask

  // n samples; optional ch0 write driven into sample wr_k (0 = none)
  task automatic measure(input int n, input int wr_k, input int wr_data,
                         output int h0, output int h1, output int ps,
                         output int m0, output int mps);
    h0 = 0; h1 = 0; ps = 0; m0 = 0; mps = 0;
    for (int k = 1; k <= n; k++) begin
      if (k == wr_k) begin
        duty_bus.duty_wr   = 1'b1;
        duty_bus.duty_sel  = '0;
        duty_bus.duty_data = wr_data[WIDTH-1:0];
      end else begin
        duty_bus.duty_wr = 1'b0;
      end
      step();
      h0 += int'(pwm_out[0]);
      h1 += int'(pwm_out[1]);
      ps += int'(period_start);
      if (k <= 32) begin
        if (pwm_out[0])   m0  |= (1 << (k - 1));
        if (period_start) mps |= (1 << (k - 1));
      end
    end
    duty_bus.duty_wr = 1'b0;
  endtask

  initial begin
    int lat, h0, h1, ps, m0, mps, exp_m0, c, acc;

    vecs[0] = '{5,  0,  0, 0, 32, 10,  0, 2};
    vecs[1] = '{8,  15, 2, 0, 48, 24, 45, 1};
    vecs[2] = '{15, 1,  0, 0, 16, 15,  1, 1};
    vecs[3] = '{3,  15, 0, 1, 30,  5, 29, 1};
    vecs[4] = '{0,  7,  1, 1, 60,  0, 26, 1};
    vecs[5] = '{12, 4,  0, 0, 16, 12,  4, 1};

    reset = 1'b1; enable = 1'b1; center_mode = 1'b0; prescale = '0;
    duty_bus.duty_wr = 1'b0; duty_bus.duty_sel = '0; duty_bus.duty_data = '0;
    repeat (3) step();
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      prescale    = vecs[v].pre[PW-1:0];
      center_mode = (vecs[v].ctr != 0);
      write_duty(0, vecs[v].d0);
      write_duty(1, vecs[v].d1);
      wait_ps($sformatf("vec%0d_sync", v), lat);
      measure(vecs[v].n, 0, 0, h0, h1, ps, m0, mps);
      check($sformatf("vec%0d_high_ch0", v), h0, vecs[v].h0);
      check($sformatf("vec%0d_high_ch1", v), h1, vecs[v].h1);
      check($sformatf("vec%0d_period_starts", v), ps, vecs[v].ps);
    end

    // Double buffer: mid-period write waits, boundary-cycle write bypasses
    write_duty(0, 5);
    wait_ps("dbuf_sync", lat);
    measure(16, 4, 12, h0, h1, ps, m0, mps);
    check("dbuf_old_period_high", h0, 5);
    check("dbuf_old_period_ps_pos", mps, 1 << 15);
    measure(16, 16, 5, h0, h1, ps, m0, mps);
    check("dbuf_new_period_high", h0, 12);
    measure(16, 0, 0, h0, h1, ps, m0, mps);
    check("bypass_period_high", h0, 5);

    // Center shape, and a mid-period mode change deferred to the boundary
    center_mode = 1'b1;
    write_duty(0, 3);
    wait_ps("center_sync", lat);
    exp_m0 = 0;
    for (int j = 0; j < 30; j++) begin
      c = (j <= 15) ? j : 30 - j;
      if (c < 3) exp_m0 |= (1 << j);
    end
    h0 = 0; h1 = 0; ps = 0; m0 = 0; mps = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) center_mode = 1'b0;
      step();
      if (pwm_out[0])   m0  |= (1 << (k - 1));
      if (period_start) mps |= (1 << (k - 1));
    end
    check("center_pulse_shape", m0, exp_m0);
    check("center_period_len", mps, 1 << 29);
    measure(16, 0, 0, h0, h1, ps, m0, mps);
    check("mode_switch_edge_shape", m0, 32'h7);
    check("mode_switch_edge_period", mps, 1 << 15);

    // Prescale shrunk below pre_cnt recovers on the next clock
    prescale = 8'd2;
    wait_ps("presc_sync", lat);
    step();
    prescale = 8'd0;
    lat = -1;
    for (int k = 2; k <= 60; k++) begin
      step();
      if (period_start) begin
        lat = k;
        break;
      end
    end
    check("presc_change_ps_pos", lat, 17);

    // Invalid selects leave both shadows alone
    write_duty(0, 15);
    write_duty(1, 4);
    write_duty(3, 0);
    write_duty(2, 0);
    wait_ps("badsel_sync", lat);
    measure(16, 0, 0, h0, h1, ps, m0, mps);
    check("badsel_ch0_high", h0, 15);
    check("badsel_ch1_high", h1, 4);

    // Reset mid-period
    wait_ps("rst_sync", lat);
    repeat (3) step();
    reset = 1'b1;
    step();
    check("midrst_pwm_out", int'(pwm_out), 0);
    check("midrst_period_start", int'(period_start), 0);
    reset = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (period_start) begin
        lat = k;
        break;
      end
    end
    check("midrst_first_boundary", lat, 16);
    measure(16, 0, 0, h0, h1, ps, m0, mps);
    check("midrst_shadow_ch0", h0, 0);
    check("midrst_shadow_ch1", h1, 0);

    // Disable, write while disabled, re-enable
    enable = 1'b0;
    step();
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      acc |= int'(pwm_out) | int'(period_start);
    end
    write_duty(0, 7);
    acc |= int'(pwm_out) | int'(period_start);
    check("disabled_outputs_low", acc, 0);
    enable = 1'b1;
    measure(16, 0, 0, h0, h1, ps, m0, mps);
    check("reenable_ch0_shape", m0, 32'h7f);
    check("reenable_ps_pos", mps, 1 << 15);
    check("reenable_ch1_high", h1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
